// File: rtl/vmask_pkg.sv
// Shared opSel codes, latency floor and accumulator sizing for the vmask_pipe mask unit.
package vmask_pkg;

    localparam logic [3:0] OP_ANDN   = 4'd0;
    localparam logic [3:0] OP_AND    = 4'd1;
    localparam logic [3:0] OP_OR     = 4'd2;
    localparam logic [3:0] OP_XOR    = 4'd3;
    localparam logic [3:0] OP_ORN    = 4'd4;
    localparam logic [3:0] OP_NAND   = 4'd5;
    localparam logic [3:0] OP_NOR    = 4'd6;
    localparam logic [3:0] OP_XNOR   = 4'd7;
    localparam logic [3:0] OP_VCPOP  = 4'd8;
    localparam logic [3:0] OP_VFIRST = 4'd9;
    localparam logic [3:0] OP_RSVD10 = 4'd10;
    localparam logic [3:0] OP_RSVD11 = 4'd11;
    localparam logic [3:0] OP_RSVD12 = 4'd12;
    localparam logic [3:0] OP_RSVD13 = 4'd13;
    localparam logic [3:0] OP_RSVD14 = 4'd14;
    localparam logic [3:0] OP_RSVD15 = 4'd15;

    localparam int unsigned LATENCY_MIN = 3;

    function automatic int unsigned acc_width(input int unsigned max_beats,
                                              input int unsigned beat_w);
        return $clog2(max_beats * beat_w) + 1;
    endfunction

endpackage

// File: rtl/vmask_reduce.sv
// Multi-beat mask reductions (vcpop.m / vfirst.m): popcount, priority encoder,
// beat counter and accumulators. Result is combinational on the in_last beat.
module vmask_reduce
    import vmask_pkg::*;
#(
    parameter int unsigned REQ_DATA_WIDTH  = 64,
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned MAX_BEATS       = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       beat_valid_i,
    input  logic                       last_i,
    input  logic                       sel_first_i,
    input  logic [REQ_DATA_WIDTH-1:0]  m0_i,
    input  logic [REQ_DATA_WIDTH-1:0]  bmask_i,
    output logic [RESP_DATA_WIDTH-1:0] res_o,
    output logic                       res_valid_o
);

    localparam int unsigned ACC_W  = acc_width(MAX_BEATS, REQ_DATA_WIDTH);
    localparam int unsigned LOG_W  = $clog2(REQ_DATA_WIDTH);
    localparam int unsigned BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [ACC_W-1:0]          cnt_q, cnt_d;
    logic [ACC_W-1:0]          idx_q, idx_d;
    logic                      found_q, found_d;
    logic [REQ_DATA_WIDTH-1:0] masked;
    logic [ACC_W-1:0]          pop;
    logic [LOG_W-1:0]          pos;
    logic                      hit;

    always_comb begin
        masked = m0_i & bmask_i;
        pop    = '0;
        hit    = 1'b0;
        pos    = '0;
        for (int unsigned i = 0; i < REQ_DATA_WIDTH; i++) begin
            pop = pop + ACC_W'(masked[i]);
            if (masked[i] && !hit) begin
                hit = 1'b1;
                pos = LOG_W'(i);
            end
        end
    end

    always_comb begin
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        found_d     = found_q;
        res_o       = '0;
        res_valid_o = 1'b0;
        if (beat_valid_i) begin
            cnt_d = cnt_q + pop;
            // Beat width is a power of two, so beat_idx*W + pos is a concatenation.
            if (!found_q && hit) begin
                found_d = 1'b1;
                idx_d   = (ACC_W'(beat_q) << LOG_W) | ACC_W'(pos);
            end
            if (last_i) begin
                res_valid_o = 1'b1;
                if (sel_first_i) begin
                    if (found_d) begin
                        res_o[ACC_W-1:0] = idx_d;
                    end else begin
                        res_o = '1;
                    end
                end else begin
                    res_o[ACC_W-1:0] = cnt_d;
                end
                beat_d  = '0;
                cnt_d   = '0;
                idx_d   = '0;
                found_d = 1'b0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            found_q <= found_d;
        end
    end

endmodule

// File: rtl/vmask_pipe.sv
// Parametrised vALU mask-register unit: logical ops with tail-undisturbed enables,
// plus vcpop/vfirst reductions when VMASK_REDUCE_EN is defined.
module vmask_pipe
    import vmask_pkg::*;
#(
    parameter int unsigned REQ_DATA_WIDTH  = 64,
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned REQ_ADDR_WIDTH  = 32,
    parameter int unsigned OPSEL_WIDTH     = 4,
    parameter int unsigned LATENCY         = 6,
    parameter int unsigned MAX_BEATS       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
    input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
    input  logic [REQ_DATA_WIDTH-1:0]  in_m1,
    input  logic [REQ_DATA_WIDTH-1:0]  in_vd,
    input  logic [REQ_DATA_WIDTH-1:0]  in_bmask,
    input  logic                       in_last,
    input  logic                       in_valid,
    input  logic [OPSEL_WIDTH-1:0]     in_opSel,
    output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
    output logic [RESP_DATA_WIDTH-1:0] out_vec,
    output logic                       out_valid
);

    localparam int unsigned NDLY = LATENCY - 2;

    if (LATENCY < LATENCY_MIN) begin : g_bad_latency
        $error("vmask_pipe: LATENCY below minimum");
    end

    logic                      s0_valid_q;
    logic [REQ_ADDR_WIDTH-1:0] s0_addr_q;
    logic [REQ_DATA_WIDTH-1:0] s0_m0_q, s0_m1_q, s0_vd_q, s0_bmask_q;
    logic [OPSEL_WIDTH-1:0]    s0_op_q;

    always_ff @(posedge clk) begin
        if (rst || !in_valid) begin
            s0_addr_q  <= '0;
            s0_m0_q    <= '0;
            s0_m1_q    <= '0;
            s0_vd_q    <= '0;
            s0_bmask_q <= '0;
            s0_op_q    <= '0;
        end else begin
            s0_addr_q  <= in_addr;
            s0_m0_q    <= in_m0;
            s0_m1_q    <= in_m1;
            s0_vd_q    <= in_vd;
            s0_bmask_q <= in_bmask;
            s0_op_q    <= in_opSel;
        end
        s0_valid_q <= in_valid && !rst;
    end

    logic [3:0] op_lo;
    logic       op_hi;
    assign op_lo = s0_op_q[3:0];
    if (OPSEL_WIDTH > 4) begin : g_op_hi
        assign op_hi = |s0_op_q[OPSEL_WIDTH-1:4];
    end else begin : g_op_nohi
        assign op_hi = 1'b0;
    end

    logic [RESP_DATA_WIDTH-1:0] s1_vec_d, s1_vec_q;
    logic [REQ_ADDR_WIDTH-1:0]  s1_addr_q;
    logic                       s1_valid_d, s1_valid_q;
    logic [REQ_DATA_WIDTH-1:0]  lop;

`ifdef VMASK_REDUCE_EN
    logic                       s0_last_q;
    logic [RESP_DATA_WIDTH-1:0] red_res;
    logic                       red_valid;
    logic                       red_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_last_q <= 1'b0;
        end else begin
            s0_last_q <= in_valid && in_last;
        end
    end

    assign red_beat = s0_valid_q && !op_hi && (op_lo == OP_VCPOP || op_lo == OP_VFIRST);

    vmask_reduce #(
        .REQ_DATA_WIDTH (REQ_DATA_WIDTH),
        .RESP_DATA_WIDTH(RESP_DATA_WIDTH),
        .MAX_BEATS      (MAX_BEATS)
    ) u_reduce (
        .clk_i       (clk),
        .rst_i       (rst),
        .beat_valid_i(red_beat),
        .last_i      (s0_last_q),
        .sel_first_i (op_lo == OP_VFIRST),
        .m0_i        (s0_m0_q),
        .bmask_i     (s0_bmask_q),
        .res_o       (red_res),
        .res_valid_o (red_valid)
    );
`else
    logic unused_last;
    assign unused_last = in_last;
`endif

    always_comb begin
        lop = '0;
        case (op_lo)
            OP_ANDN: lop = s0_m0_q & ~s0_m1_q;
            OP_AND:  lop = s0_m0_q & s0_m1_q;
            OP_OR:   lop = s0_m0_q | s0_m1_q;
            OP_XOR:  lop = s0_m0_q ^ s0_m1_q;
            OP_ORN:  lop = s0_m0_q | ~s0_m1_q;
            OP_NAND: lop = ~(s0_m0_q & s0_m1_q);
            OP_NOR:  lop = ~(s0_m0_q | s0_m1_q);
            OP_XNOR: lop = ~(s0_m0_q ^ s0_m1_q);
            default: lop = '0;
        endcase
    end

    // Reserved codes fall through with a zero result and valid tracking the beat.
    always_comb begin
        s1_vec_d   = '0;
        s1_valid_d = s0_valid_q;
        if (!op_hi) begin
            if (op_lo <= OP_XNOR) begin
                s1_vec_d[REQ_DATA_WIDTH-1:0] = (s0_bmask_q & lop) | (~s0_bmask_q & s0_vd_q);
            end
`ifdef VMASK_REDUCE_EN
            else if (op_lo == OP_VCPOP || op_lo == OP_VFIRST) begin
                s1_vec_d   = red_res;
                s1_valid_d = red_valid;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vec_q   <= '0;
            s1_addr_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_vec_q   <= s1_vec_d;
            s1_addr_q  <= s0_addr_q;
            s1_valid_q <= s1_valid_d;
        end
    end

    logic [RESP_DATA_WIDTH-1:0] dly_vec_q   [NDLY];
    logic [REQ_ADDR_WIDTH-1:0]  dly_addr_q  [NDLY];
    logic                       dly_valid_q [NDLY];

    for (genvar g = 0; g < NDLY; g++) begin : g_dly
        logic [RESP_DATA_WIDTH-1:0] vec_d;
        logic [REQ_ADDR_WIDTH-1:0]  addr_d;
        logic                       valid_d;

        if (g == 0) begin : g_src
            assign vec_d   = s1_vec_q;
            assign addr_d  = s1_addr_q;
            assign valid_d = s1_valid_q;
        end else begin : g_src
            assign vec_d   = dly_vec_q[g-1];
            assign addr_d  = dly_addr_q[g-1];
            assign valid_d = dly_valid_q[g-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dly_vec_q[g]   <= '0;
                dly_addr_q[g]  <= '0;
                dly_valid_q[g] <= 1'b0;
            end else begin
                dly_vec_q[g]   <= vec_d;
                dly_addr_q[g]  <= addr_d;
                dly_valid_q[g] <= valid_d;
            end
        end
    end

    assign out_vec   = dly_vec_q[NDLY-1];
    assign out_addr  = dly_addr_q[NDLY-1];
    assign out_valid = dly_valid_q[NDLY-1];

endmodule

// File: tb/tb_vmask_pipe.sv
// Directed self-checking bench for vmask_pipe; reduction steps run when VMASK_REDUCE_EN is defined.
module tb_vmask_pipe;

    localparam int unsigned LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_addr;
    logic [63:0] in_m0, in_m1, in_vd, in_bmask;
    logic        in_last, in_valid;
    logic [3:0]  in_opSel;
    logic [31:0] out_addr;
    logic [63:0] out_vec;
    logic        out_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc    = 0;
    int acc_s [8];

    int          mq_cyc  [$];
    logic [31:0] mq_addr [$];
    logic [63:0] mq_vec  [$];

    vmask_pipe #(
        .REQ_DATA_WIDTH (64),
        .RESP_DATA_WIDTH(64),
        .REQ_ADDR_WIDTH (32),
        .OPSEL_WIDTH    (4),
        .LATENCY        (LAT),
        .MAX_BEATS      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_addr  (in_addr),
        .in_m0    (in_m0),
        .in_m1    (in_m1),
        .in_vd    (in_vd),
        .in_bmask (in_bmask),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_opSel (in_opSel),
        .out_addr (out_addr),
        .out_vec  (out_vec),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            mq_cyc.push_back(cyc);
            mq_addr.push_back(out_addr);
            mq_vec.push_back(out_vec);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [3:0] op, input logic [31:0] a, input logic [63:0] m0,
                        input logic [63:0] m1, input logic [63:0] vd, input logic [63:0] bm,
                        input logic last);
        in_valid = 1'b1;
        in_opSel = op;
        in_addr  = a;
        in_m0    = m0;
        in_m1    = m1;
        in_vd    = vd;
        in_bmask = bm;
        in_last  = last;
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_opSel = '0;
        in_addr  = '0;
        in_m0    = '0;
        in_m1    = '0;
        in_vd    = '0;
        in_bmask = '0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input int ecyc, input logic [31:0] eaddr,
                              input logic [63:0] evec);
        checks++;
        assert (mq_vec.size() > 0) else begin
            errors++;
            $error("FAIL %s: got no result expected %h", tag, evec);
        end
        if (mq_vec.size() > 0) begin
            check({tag, "_cyc"}, 64'(mq_cyc.pop_front()), 64'(ecyc));
            check({tag, "_addr"}, 64'(mq_addr.pop_front()), 64'(eaddr));
            check({tag, "_vec"}, mq_vec.pop_front(), evec);
        end
    endtask

    initial begin
        logic [63:0] exp_s [8];
        exp_s = '{64'h4, 64'h8, 64'hE, 64'h6, 64'hD, 64'h7, 64'h1, 64'h9};

        rst = 1'b1;
        idle(3);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_vec", out_vec, 64'h0);
        check("rst_addr", 64'(out_addr), 64'h0);
        rst = 1'b0;
        idle(2);

        beat(4'd3, 32'h100, 64'hF0F0, 64'hFF00, 64'h0, '1, 1'b0);
        idle(LAT + 2);
        expect_out("xor", acc + LAT - 1, 32'h100, 64'h0FF0);

        beat(4'd1, 32'h101, '1, '1, 64'h0, 64'h00FF, 1'b0);
        idle(LAT + 2);
        expect_out("and_tail", acc + LAT - 1, 32'h101, 64'h00FF);

        beat(4'd4, 32'h102, 64'h0, '1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_0000_0000_0000, 1'b0);
        idle(LAT + 2);
        expect_out("orn_tail", acc + LAT - 1, 32'h102, 64'h0000_AAAA_AAAA_AAAA);

        for (int i = 0; i < 8; i++) begin
            beat(4'(i), 32'h20 + 32'(i), 64'hC, 64'hA, 64'h0, 64'hF, 1'b0);
            acc_s[i] = acc;
        end
        idle(LAT + 2);
        for (int i = 0; i < 8; i++) begin
            expect_out("stream", acc_s[0] + LAT - 1 + i, 32'h20 + 32'(i), exp_s[i]);
        end

        beat(4'd12, 32'h130, '1, '1, '1, '1, 1'b1);
        idle(LAT + 2);
        expect_out("rsvd12", acc + LAT - 1, 32'h130, 64'h0);

`ifdef VMASK_REDUCE_EN
        beat(4'd8, 32'h200, 64'h1, 64'h0, 64'h0, '1, 1'b0);
        beat(4'd8, 32'h201, 64'h3, 64'h0, 64'h0, '1, 1'b0);
        beat(4'd8, 32'h202, 64'hFF, 64'h0, 64'h0, '1, 1'b1);
        idle(LAT + 2);
        expect_out("vcpop3", acc + LAT - 1, 32'h202, 64'd11);
        check("vcpop3_single", 64'(mq_vec.size()), 64'h0);

        beat(4'd9, 32'h210, 64'h0, 64'h0, 64'h0, '1, 1'b0);
        beat(4'd9, 32'h211, 64'h10, 64'h0, 64'h0, '1, 1'b1);
        idle(LAT + 2);
        expect_out("vfirst68", acc + LAT - 1, 32'h211, 64'd68);

        beat(4'd9, 32'h220, 64'h0, 64'h0, 64'h0, '1, 1'b0);
        beat(4'd9, 32'h221, 64'hF0, 64'h0, 64'h0, 64'h0, 1'b1);
        idle(LAT + 2);
        expect_out("vfirst_none", acc + LAT - 1, 32'h221, '1);

        beat(4'd8, 32'h230, 64'hFF, 64'h0, 64'h0, 64'h0F, 1'b0);
        beat(4'd3, 32'h55, 64'hFF, 64'h0, 64'h0, '1, 1'b1);
        acc_s[0] = acc;
        beat(4'd8, 32'h231, 64'h3, 64'h0, 64'h0, '1, 1'b1);
        idle(LAT + 2);
        expect_out("interleave_log", acc_s[0] + LAT - 1, 32'h55, 64'hFF);
        expect_out("interleave_cpop", acc + LAT - 1, 32'h231, 64'd6);

        beat(4'd8, 32'h240, 64'h3, 64'h0, 64'h0, '1, 1'b1);
        acc_s[0] = acc;
        beat(4'd8, 32'h241, 64'h1, 64'h0, 64'h0, '1, 1'b1);
        idle(LAT + 2);
        expect_out("b2b_first", acc_s[0] + LAT - 1, 32'h240, 64'd2);
        expect_out("b2b_second", acc + LAT - 1, 32'h241, 64'd1);

        beat(4'd8, 32'h70, 64'hFF, 64'h0, 64'h0, '1, 1'b0);
        beat(4'd8, 32'h71, 64'hFF, 64'h0, 64'h0, '1, 1'b0);
        beat(4'd2, 32'h72, 64'h1, 64'h0, 64'h0, '1, 1'b0);
        rst = 1'b1;
        idle(1);
        check("midrst_valid", 64'(out_valid), 64'h0);
        check("midrst_vec", out_vec, 64'h0);
        idle(2);
        rst = 1'b0;
        beat(4'd8, 32'h80, 64'h7, 64'h0, 64'h0, '1, 1'b1);
        idle(LAT + 2);
        expect_out("post_rst_cpop", acc + LAT - 1, 32'h80, 64'd3);
`else
        beat(4'd8, 32'h90, 64'hFF, 64'h0, 64'h0, '1, 1'b0);
        acc_s[0] = acc;
        beat(4'd9, 32'h91, 64'hFF, 64'h0, 64'h0, '1, 1'b1);
        idle(LAT + 2);
        expect_out("rsvd8", acc_s[0] + LAT - 1, 32'h90, 64'h0);
        expect_out("rsvd9", acc + LAT - 1, 32'h91, 64'h0);

        beat(4'd2, 32'h72, 64'h1, 64'h0, 64'h0, '1, 1'b0);
        rst = 1'b1;
        idle(1);
        check("midrst_valid", 64'(out_valid), 64'h0);
        idle(2);
        rst = 1'b0;
        idle(LAT + 2);
`endif

        check("drained", 64'(mq_vec.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
